spectrum_line_ctrl: RTL and testbench

Sequences the per-line spectrum drawer in the FIR audio LCD path. It owns the frequency-bin counter `line_cnt`. It services each `data_req` by reading one magnitude from a double-buffered FFT result RAM, then scales and clamps it to a bar length `line_length`. It swaps the RAM buffers only at frame boundaries, with a ready/free handshake to the FFT writer. It sits between the FFT magnitude store and the LCD pixel display block, in the `lcd_clk` domain.

---
 rtl/spectrum_line_ctrl_pkg.sv | 32 +++
 rtl/spectrum_line_ctrl_buf_swap.sv | 54 +++++
 rtl/spectrum_line_ctrl.sv | 157 +++++++++++++++
 tb/tb_spectrum_line_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_line_ctrl_pkg.sv
// Shared constants, fetch FSM encoding and the magnitude scaling helper
// for the spectrum line controller.
package spectrum_line_ctrl_pkg;

  localparam int H_LCD_DISP  = 480;
  localparam int LCD_MAX_LEN = H_LCD_DISP - 1;
  localparam int ADDR_W      = 8;
  localparam int BIN_W       = 7;
  localparam int DATA_W      = 16;
  localparam int LAT_W       = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } fetch_state_e;

  // Shift the raw magnitude down and saturate it at the longest drawable bar.
  function automatic logic [DATA_W-1:0] scale_clamp(input logic [DATA_W-1:0] raw,
                                                    input int shift,
                                                    input int max_len);
    logic [DATA_W-1:0] len;
    len = raw >> shift;
    if (len > DATA_W'(max_len)) begin
      return DATA_W'(max_len);
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/spectrum_line_ctrl_buf_swap.sv
// Front/back buffer ownership between the display and the FFT writer;
// a filled back buffer is only swapped in at a frame boundary.
module spec_buf_swap
  import spectrum_line_ctrl_pkg::*;
(
  input  logic lcd_clk,
  input  logic sys_rst,
  input  logic fft_ready,
  input  logic frame_end,
  output logic buf_sel,
  output logic wr_buf_free
);

  logic pending_r;
  logic pending_nxt_s;
  logic buf_sel_r;
  logic buf_sel_nxt_s;
  logic wr_buf_free_r;

  // Swap decision at frame end, otherwise remember a ready back buffer.
  always_comb begin
    pending_nxt_s = pending_r;
    buf_sel_nxt_s = buf_sel_r;
    if (frame_end) begin
      if (pending_r | fft_ready) begin
        buf_sel_nxt_s = ~buf_sel_r;
        pending_nxt_s = 1'b0;
      end else begin
        buf_sel_nxt_s = buf_sel_r;
      end
    end else if (fft_ready) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Swap state registers.
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pending_r     <= 1'b0;
      buf_sel_r     <= 1'b0;
      wr_buf_free_r <= 1'b1;
    end else begin
      pending_r     <= pending_nxt_s;
      buf_sel_r     <= buf_sel_nxt_s;
      wr_buf_free_r <= ~pending_nxt_s;
    end
  end

  assign buf_sel     = buf_sel_r;
  assign wr_buf_free = wr_buf_free_r;

endmodule

// File: rtl/spectrum_line_ctrl.sv
// Per-line spectrum drawer sequencer: walks the frequency bins, fetches one
// magnitude per display request and turns it into a clamped bar length.
module spectrum_line_ctrl
  import spectrum_line_ctrl_pkg::*;
#(
  parameter int N_POINTS    = 128,
  parameter int RD_LAT      = 2,
  parameter int SCALE_SHIFT = 4,
  parameter int MAX_LEN     = LCD_MAX_LEN
) (
  input  logic              lcd_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              data_req,
  input  logic              wr_over,
  input  logic              fft_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [BIN_W-1:0]  line_cnt,
  output logic [DATA_W-1:0] line_length,
  output logic              buf_sel,
  output logic              wr_buf_free,
  output logic              frame_done,
  output logic              overrun
);

  fetch_state_e      state_r, state_nxt_s;
  logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_nxt_s;
  logic              rd_en_r, rd_en_nxt_s;
  logic [ADDR_W-1:0] rd_addr_r, rd_addr_nxt_s;
  logic [DATA_W-1:0] cap_r, cap_nxt_s;
  logic [DATA_W-1:0] line_length_r, line_length_nxt_s;
  logic              overrun_r, overrun_nxt_s;
  logic [BIN_W-1:0]  line_cnt_r, line_cnt_nxt_s;
  logic              frame_end_s;
  logic              frame_done_r;
  logic              buf_sel_s;

  // Fetch sequencing; frame_start aborts whatever fetch is in flight.
  always_comb begin
    state_nxt_s       = state_r;
    lat_cnt_nxt_s     = lat_cnt_r;
    rd_en_nxt_s       = 1'b0;
    rd_addr_nxt_s     = rd_addr_r;
    cap_nxt_s         = cap_r;
    line_length_nxt_s = line_length_r;
    overrun_nxt_s     = overrun_r;
    if (frame_start) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (data_req) begin
            state_nxt_s   = READ;
            rd_en_nxt_s   = 1'b1;
            rd_addr_nxt_s = {buf_sel_s, line_cnt_r};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        READ: begin
          state_nxt_s   = WAIT;
          lat_cnt_nxt_s = LAT_W'(RD_LAT - 1);
        end
        WAIT: begin
          if (lat_cnt_r == {LAT_W{1'b0}}) begin
            state_nxt_s = CAPTURE;
            cap_nxt_s   = rd_data;
          end else begin
            lat_cnt_nxt_s = lat_cnt_r - LAT_W'(1);
          end
        end
        CAPTURE: begin
          line_length_nxt_s = scale_clamp(cap_r, SCALE_SHIFT, MAX_LEN);
          state_nxt_s       = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
      if (data_req && (state_r != IDLE)) begin
        overrun_nxt_s = 1'b1;
      end else begin
        overrun_nxt_s = overrun_r;
      end
    end
  end

  // Fetch state and registered fetch outputs.
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r       <= IDLE;
      lat_cnt_r     <= {LAT_W{1'b0}};
      rd_en_r       <= 1'b0;
      rd_addr_r     <= {ADDR_W{1'b0}};
      cap_r         <= {DATA_W{1'b0}};
      line_length_r <= {DATA_W{1'b0}};
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      lat_cnt_r     <= lat_cnt_nxt_s;
      rd_en_r       <= rd_en_nxt_s;
      rd_addr_r     <= rd_addr_nxt_s;
      cap_r         <= cap_nxt_s;
      line_length_r <= line_length_nxt_s;
      overrun_r     <= overrun_nxt_s;
    end
  end

  // Bin counter; only a wrap caused by wr_over marks a frame end.
  always_comb begin
    line_cnt_nxt_s = line_cnt_r;
    frame_end_s    = 1'b0;
    if (frame_start) begin
      line_cnt_nxt_s = {BIN_W{1'b0}};
    end else if (wr_over) begin
      if (line_cnt_r == BIN_W'(N_POINTS - 1)) begin
        line_cnt_nxt_s = {BIN_W{1'b0}};
        frame_end_s    = 1'b1;
      end else begin
        line_cnt_nxt_s = line_cnt_r + BIN_W'(1);
      end
    end else begin
      line_cnt_nxt_s = line_cnt_r;
    end
  end

  // Bin counter and frame-done pulse registers.
  always_ff @(posedge lcd_clk or posedge sys_rst) begin
    if (sys_rst) begin
      line_cnt_r   <= {BIN_W{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      line_cnt_r   <= line_cnt_nxt_s;
      frame_done_r <= frame_end_s;
    end
  end

  spec_buf_swap u_buf_swap (
    .lcd_clk     (lcd_clk),
    .sys_rst     (sys_rst),
    .fft_ready   (fft_ready),
    .frame_end   (frame_end_s),
    .buf_sel     (buf_sel_s),
    .wr_buf_free (wr_buf_free)
  );

  assign rd_en       = rd_en_r;
  assign rd_addr     = rd_addr_r;
  assign line_cnt    = line_cnt_r;
  assign line_length = line_length_r;
  assign buf_sel     = buf_sel_s;
  assign frame_done  = frame_done_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_spectrum_line_ctrl.sv
// Scoreboard bench for spectrum_line_ctrl: directed scenarios plus random
// traffic, checked against a frame/bin/buffer model and a RAM model.
module tb_spectrum_line_ctrl;

  localparam int N      = 128;
  localparam int RD_LAT = 2;
  localparam int SHIFT  = 4;
  localparam int MAXL   = 479;

  logic        lcd_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_start = 1'b0, data_req = 1'b0, wr_over = 1'b0, fft_ready = 1'b0;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [6:0]  line_cnt;
  logic [15:0] line_length;
  logic        buf_sel, wr_buf_free, frame_done, overrun;

  spectrum_line_ctrl #(.N_POINTS(N), .RD_LAT(RD_LAT), .SCALE_SHIFT(SHIFT), .MAX_LEN(MAXL)) dut (
    .lcd_clk(lcd_clk), .sys_rst(sys_rst), .frame_start(frame_start), .data_req(data_req),
    .wr_over(wr_over), .fft_ready(fft_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .line_cnt(line_cnt), .line_length(line_length), .buf_sel(buf_sel),
    .wr_buf_free(wr_buf_free), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 lcd_clk = ~lcd_clk;

  // RAM model: data for an accepted strobe appears RD_LAT edges later, junk otherwise.
  logic [15:0] mem [256];
  logic        pv [RD_LAT];
  logic [7:0]  pa [RD_LAT];
  always @(posedge lcd_clk) begin
    pv[0] <= rd_en;
    pa[0] <= rd_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign rd_data = (pv[RD_LAT-1] === 1'b1) ? mem[pa[RD_LAT-1]] : 16'h0123;

  typedef struct { int cyc; logic [15:0] val; } ent_t;
  ent_t rq[$];
  ent_t lq[$];

  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  bit   chk_en = 1'b0;
  int   m_cnt = 0, busy_end = -100;
  bit   m_sel = 1'b0, m_pend = 1'b0, m_ovr = 1'b0, m_fdone = 1'b0;
  logic [15:0] m_ll = 16'd0;
  ent_t e_mon;
  bit   exp_rd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_len(input logic [15:0] raw);
    int v;
    v = int'(raw) / (2 ** SHIFT);
    return 16'((v > MAXL) ? MAXL : v);
  endfunction

  // Reference behaviour for one clock edge with the given input pulses.
  task automatic model_edge(input bit dq, input bit wo, input bit fr, input bit fs);
    bit wrapped;
    logic [7:0] a;
    wrapped = 1'b0;
    m_fdone = 1'b0;
    if (fs) begin
      m_cnt = 0;
      while (lq.size() > 0 && lq[lq.size()-1].cyc >= cyc) void'(lq.pop_back());
      busy_end = cyc;
    end else begin
      if (dq) begin
        if (cyc > busy_end) begin
          a = {m_sel, 7'(m_cnt)};
          rq.push_back('{cyc: cyc, val: 16'(a)});
          lq.push_back('{cyc: cyc + RD_LAT + 2, val: ref_len(mem[a])});
          busy_end = cyc + RD_LAT + 2;
        end else begin
          m_ovr = 1'b1;
        end
      end
      if (wo) begin
        if (m_cnt == N - 1) begin
          m_cnt = 0;
          m_fdone = 1'b1;
          wrapped = 1'b1;
          if (m_pend || fr) begin
            m_sel = ~m_sel;
            m_pend = 1'b0;
          end
        end else begin
          m_cnt++;
        end
      end
    end
    if (fr && !wrapped) m_pend = 1'b1;
  endtask

  task automatic step(input bit dq, input bit wo, input bit fr, input bit fs);
    data_req = dq; wr_over = wo; fft_ready = fr; frame_start = fs;
    @(posedge lcd_clk);
    cyc++;
    model_edge(dq, wo, fr, fs);
    @(negedge lcd_clk);
    data_req = 1'b0; wr_over = 1'b0; fft_ready = 1'b0; frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
    check({tag, "_line_length"}, 32'(line_length), 32'd0);
    check({tag, "_buf_sel"}, 32'(buf_sel), 32'd0);
    check({tag, "_wr_buf_free"}, 32'(wr_buf_free), 32'd1);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // Monitor: pops the scoreboard when the DUT strobes the RAM or a bar length falls due.
  always @(negedge lcd_clk) begin
    if (sys_rst) begin
      m_ll = 16'd0;
    end else if (chk_en) begin
      exp_rd = (rq.size() > 0) && (rq[0].cyc == cyc);
      check("rd_en", 32'(rd_en), 32'(exp_rd));
      if (exp_rd) begin
        e_mon = rq.pop_front();
        check("rd_addr", 32'(rd_addr), 32'(e_mon.val));
      end
      if (lq.size() > 0 && lq[0].cyc == cyc) begin
        e_mon = lq.pop_front();
        m_ll = e_mon.val;
      end
      check("line_length", 32'(line_length), 32'(m_ll));
      check("line_cnt", 32'(line_cnt), 32'(m_cnt));
      check("buf_sel", 32'(buf_sel), 32'(m_sel));
      check("wr_buf_free", 32'(wr_buf_free), 32'(!m_pend));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("frame_done", 32'(frame_done), 32'(m_fdone));
    end
  end

  initial begin
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 9000));
    mem[0] = 16'h0640;
    mem[1] = 16'hFFFF;
    mem[2] = 16'h000F;

    repeat (2) @(posedge lcd_clk);
    @(negedge lcd_clk);
    check_reset_values("reset");
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    // First fetch: bin 0 of buffer 0, 0x0640 >> 4 = 100.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(RD_LAT + 3);
    check("ll_scaled", 32'(line_length), 32'd100);

    // Saturating and truncating magnitudes.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("ll_clamp", 32'(line_length), 32'd479);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("ll_zero", 32'(line_length), 32'd0);

    // Whole frame without a ready back buffer.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (N) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("no_swap_sel", 32'(buf_sel), 32'd0);

    // Ready mid-frame, swap at the frame end, fetch from the new front buffer.
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("free_low", 32'(wr_buf_free), 32'd0);
    repeat (N - 10) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check("swap_sel", 32'(buf_sel), 32'd1);
    check("swap_free", 32'(wr_buf_free), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Ready coinciding with the last wr_over swaps immediately.
    repeat (N - 1) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("same_cycle_swap", 32'(buf_sel), 32'd0);

    // Back-to-back requests: second one is dropped.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    check("overrun_set", 32'(overrun), 32'd1);

    // Data request together with wr_over, then frame_start during WAIT.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);
    check("fs_line_cnt", 32'(line_cnt), 32'd0);

    // Random traffic.
    repeat (3000)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    idle(6);

    // Async reset mid-fetch with buffer 1 in front and a pending back buffer.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    if (!m_sel) begin
      repeat (N - 1) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_sel", 32'(buf_sel), 32'd1);
    check("pre_rst_free", 32'(wr_buf_free), 32'd0);
    chk_en = 1'b0;
    #1 sys_rst = 1'b1;
    #1 check_reset_values("async_rst");
    m_cnt = 0; m_sel = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_fdone = 1'b0;
    busy_end = -100;
    rq.delete();
    lq.delete();
    repeat (2) @(posedge lcd_clk);
    @(negedge lcd_clk);
    sys_rst = 1'b0;
    chk_en  = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    check("rq_drained", 32'(rq.size()), 32'd0);
    check("lq_drained", 32'(lq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
